// File: rtl/delay_pkg.sv
// Shared definitions for the delay-time switch path and the delay core.
package delay_pkg;

    // Width of the delay-time switch code.
    localparam int unsigned DTIME_W = 4;

    // Debounce FSM states.
    typedef enum logic {
        STABLE,
        SETTLING
    } db_state_t;

    // Gray code to binary index: idx[W-1] = g[W-1]; idx[i] = idx[i+1] ^ g[i].
    function automatic logic [DTIME_W-1:0] gray2bin(input logic [DTIME_W-1:0] g);
        logic [DTIME_W-1:0] idx;
        idx[DTIME_W-1] = g[DTIME_W-1];
        for (int i = int'(DTIME_W) - 2; i >= 0; i--) begin
            idx[i] = idx[i+1] ^ g[i];
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Per-bit flop-chain synchroniser with an asynchronous, active-high reset value.
// The output is the last stage; no logic sits between stages.
module sync_ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the raw input through DEPTH flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/dtime_debounce.sv
// Debouncer for the Gray-coded delay-time rotary switch. A code is published
// on dtime/dtime_idx only after it has been seen unchanged for DB_CYCLES
// consecutive cycles; bounces back to the current code abandon the candidate.
// WIDTH must equal DTIME_W (gray2bin is fixed width), SYNC_STAGES >= 2,
// DB_CYCLES >= 2 and 2**CNT_W > DB_CYCLES.
module dtime_debounce
    import delay_pkg::*;
#(
    parameter int unsigned      WIDTH       = DTIME_W,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      DB_CYCLES   = 65536,
    parameter int unsigned      CNT_W       = 17,
    parameter logic [WIDTH-1:0] RESET_CODE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] dtime,
    output logic [WIDTH-1:0] dtime_idx,
    output logic             changed,
    output logic             settling
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [WIDTH-1:0] RESET_IDX = gray2bin(RESET_CODE);

    logic [WIDTH-1:0] sync;

    db_state_t        state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dtime_q, dtime_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             changed_q, changed_d;

    sync_ff #(
        .WIDTH     (WIDTH),
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (RESET_CODE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sync)
    );

    // Next-state: track a candidate, time it, commit or abandon it.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        dtime_d   = dtime_q;
        idx_d     = idx_q;
        changed_d = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync != dtime_q) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                if (sync == dtime_q) begin
                    // Bounced back to the published code: drop the candidate.
                    state_d = STABLE;
                end else if (sync != cand_q) begin
                    // A different code appeared mid-rotation: restart timing.
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    dtime_d   = cand_q;
                    idx_d     = gray2bin(cand_q);
                    changed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // State and output registers; reset abandons any candidate silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STABLE;
            cand_q    <= RESET_CODE;
            cnt_q     <= '0;
            dtime_q   <= RESET_CODE;
            idx_q     <= RESET_IDX;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            dtime_q   <= dtime_d;
            idx_q     <= idx_d;
            changed_q <= changed_d;
        end
    end

    assign dtime     = dtime_q;
    assign dtime_idx = idx_q;
    assign changed   = changed_q;
    assign settling  = (state_q == SETTLING);

endmodule

// File: tb/tb_dtime_debounce.sv
// Directed bench for dtime_debounce with DB_CYCLES=8, SYNC_STAGES=2.
// A clean step driven just after edge T commits at edge T+11.
module tb_dtime_debounce;

    logic       clk;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] dtime;
    logic [3:0] dtime_idx;
    logic       changed;
    logic       settling;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_pulse  = 0;
    int n_settle = 0;
    int p0;
    int s0;

    dtime_debounce #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (8),
        .CNT_W       (4),
        .RESET_CODE  (4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .dtime     (dtime),
        .dtime_idx (dtime_idx),
        .changed   (changed),
        .settling  (settling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with changed / settling high, sampled mid-cycle.
    always @(negedge clk) begin
        if (changed === 1'b1) n_pulse++;
        if (settling === 1'b1) n_settle++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        sw_in = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        sw_in = 4'b0000;
        wait_edges(3);
        check("rst_dtime",    32'(dtime),    32'h0);
        check("rst_idx",      32'(dtime_idx), 32'h0);
        check("rst_changed",  32'(changed),  32'h0);
        check("rst_settling", 32'(settling), 32'h0);

        // Idle after reset: nothing moves.
        @(negedge clk);
        rst = 1'b0;
        p0  = n_pulse;
        s0  = n_settle;
        wait_edges(50);
        check("idle_dtime",    32'(dtime),        32'h0);
        check("idle_idx",      32'(dtime_idx),    32'h0);
        check("idle_pulses",   32'(n_pulse - p0), 32'h0);
        check("idle_settle",   32'(n_settle - s0), 32'h0);

        // Clean step 0000 -> 0011.
        p0 = n_pulse;
        @(negedge clk);
        sw_in = 4'b0011;
        wait_edges(2);
        check("step_settling_t2", 32'(settling), 32'h0);
        wait_edges(1);
        check("step_settling_t3", 32'(settling), 32'h1);
        wait_edges(7);
        check("step_changed_t10", 32'(changed), 32'h0);
        check("step_dtime_t10",   32'(dtime),   32'h0);
        wait_edges(1);
        check("step_changed_t11", 32'(changed),   32'h1);
        check("step_dtime_t11",   32'(dtime),     32'h3);
        check("step_idx_t11",     32'(dtime_idx), 32'h2);
        wait_edges(1);
        check("step_changed_t12", 32'(changed),       32'h0);
        check("step_settling_t12", 32'(settling),     32'h0);
        check("step_pulses",      32'(n_pulse - p0),  32'h1);

        // Toggle 0001/0000 every 3 cycles, then settle on 0001.
        do_reset();
        p0 = n_pulse;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            sw_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (3) @(posedge clk);
        end
        #1;
        check("tog_dtime",    32'(dtime),        32'h0);
        check("tog_pulses",   32'(n_pulse - p0), 32'h0);
        check("tog_settling", 32'(settling),     32'h0);
        @(negedge clk);
        sw_in = 4'b0001;
        wait_edges(10);
        check("tog_dtime_t10", 32'(dtime), 32'h0);
        wait_edges(1);
        check("tog_dtime_t11",   32'(dtime),     32'h1);
        check("tog_idx_t11",     32'(dtime_idx), 32'h1);
        check("tog_changed_t11", 32'(changed),   32'h1);
        wait_edges(3);
        check("tog_pulses_end", 32'(n_pulse - p0), 32'h1);

        // Short glitch to 0001: settling for 4 cycles, no commit.
        do_reset();
        p0 = n_pulse;
        s0 = n_settle;
        @(negedge clk);
        sw_in = 4'b0001;
        repeat (4) @(posedge clk);
        @(negedge clk);
        sw_in = 4'b0000;
        wait_edges(6);
        check("gl_dtime",    32'(dtime),         32'h0);
        check("gl_settling", 32'(settling),      32'h0);
        check("gl_settle_n", 32'(n_settle - s0), 32'h4);
        check("gl_pulses",   32'(n_pulse - p0),  32'h0);

        // Rotation 0001 -> 0011 -> 0010, only the last one commits.
        do_reset();
        p0 = n_pulse;
        @(negedge clk);
        sw_in = 4'b0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        sw_in = 4'b0011;
        repeat (5) @(posedge clk);
        @(negedge clk);
        sw_in = 4'b0010;
        wait_edges(10);
        check("rot_dtime_t10",   32'(dtime),         32'h0);
        check("rot_pulses_t10",  32'(n_pulse - p0),  32'h0);
        wait_edges(1);
        check("rot_dtime_t11",   32'(dtime),     32'h2);
        check("rot_idx_t11",     32'(dtime_idx), 32'h3);
        check("rot_changed_t11", 32'(changed),   32'h1);
        wait_edges(3);
        check("rot_pulses_end", 32'(n_pulse - p0), 32'h1);

        // Reset mid-settling toward 1000, then re-adopt 1000 after release.
        do_reset();
        p0 = n_pulse;
        @(negedge clk);
        sw_in = 4'b1000;
        wait_edges(3);
        check("rs_settling_t3", 32'(settling), 32'h1);
        wait_edges(4);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_dtime",    32'(dtime),     32'h0);
        check("rs_async_idx",      32'(dtime_idx), 32'h0);
        check("rs_async_settling", 32'(settling),  32'h0);
        check("rs_async_changed",  32'(changed),   32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(10);
        check("rs_dtime_t10",  32'(dtime),        32'h0);
        check("rs_pulses_t10", 32'(n_pulse - p0), 32'h0);
        wait_edges(1);
        check("rs_dtime_t11",   32'(dtime),     32'h8);
        check("rs_idx_t11",     32'(dtime_idx), 32'hf);
        check("rs_changed_t11", 32'(changed),   32'h1);
        wait_edges(3);
        check("rs_pulses_end", 32'(n_pulse - p0), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
